play_timer: RTL and testbench
=============================

Name: play_timer

Overview:
Parametrised successor to the single-purpose minute/second play counter that feeds the 7-segment time display. It tracks the current song index with wrap-around and keeps an elapsed mm:ss counter and a remaining-time mm:ss countdown, both in BCD. It honours pause and outputs BCD digits directly to display_num, which removes the minute*100+second multiply at the top level. It sits between the bluetooth/mp3 control pulses and display_num.

Parameters:
CLK_HZ, 100_000_000, clk cycles per second; prescaler terminal count is CLK_HZ-1.
NUM_SONGS, 4, number of tracks; must be >= 2.
TRK_W, $clog2(NUM_SONGS), width of the track index.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
i_pause  in  1  level; 1 holds the prescaler and both counters.
i_next  in  1  next-song request, edge-detected internally.
i_pre  in  1  previous-song request, edge-detected internally.
i_finish_song  in  1  end-of-song from the mp3 block, edge-detected internally.
i_mode  in  1  0 = show elapsed, 1 = show remaining.
i_len_bcd  in  16  length of the new song as {min_tens, min_ones, sec_tens, sec_ones} BCD; sampled on a song change.
o_track  out  TRK_W  current track index.
o_time_bcd  out  16  selected time {mm, ss} as 4 BCD nibbles.
o_tick  out  1  one-cycle pulse per counted second.
o_ovf  out  1  elapsed time has saturated at 99:59.
o_rem_zero  out  1  remaining time is 00:00.

Behaviour:
- Reset (async, rst_n=0) sets every output to 0: track 0, time 0000, tick 0, ovf 0, rem_zero 0. Prescaler, both counters and edge-detect history registers are also 0. A load_pending flag is set to 1.
- Edge detect: an event is a rising edge (current=1, registered previous=0). History registers reset to 0, so an input held high through reset release counts as an edge on the first clock.
- Song change: one event per cycle, priority finish > next > pre; lower-priority simultaneous edges are dropped.
  - finish/next: track+1, wrapping NUM_SONGS-1 to 0.
  - pre: track-1, wrapping 0 to NUM_SONGS-1.
  - Registered; o_track updates the cycle after the edge.
  - Same cycle: prescaler := 0, elapsed := 00:00, remaining := i_len_bcd, o_ovf := 0, pause state untouched.
- load_pending: on the first clock after reset release, remaining := i_len_bcd and the flag clears. A song change in that same cycle takes precedence and also clears the flag.
- Prescaler: increments when i_pause=0. At CLK_HZ-1 it wraps to 0 and raises an internal sec_tick. o_tick is that pulse registered, one cycle late. A song-change cycle suppresses sec_tick.
- Elapsed BCD up-count on sec_tick:
  - sec_ones 9→0 carries into sec_tens; sec_tens 5→0 carries into min_ones; min_ones 9→0 carries into min_tens.
  - At 99:59 it holds and o_ovf=1 until the next song change.
- Remaining BCD down-count on sec_tick:
  - Borrows mirror the carries: sec_ones 0→9, sec_tens 0→5, min_ones 0→9.
  - Saturates at 00:00; o_rem_zero = (remaining==0), registered.
  - No auto-advance: the mp3 block's i_finish_song owns song end.
- i_len_bcd nibbles >9 (or sec_tens >5) are out of contract; the result is don't-care, but the block must not lock up.
- o_time_bcd = i_mode ? remaining : elapsed. It is registered, so it lags a counter update or a mode switch by one cycle.
- Pause during a song change: the change still applies and the counters stay frozen afterwards.

Decomposition:
- Shared package: BCD nibble typedef, the mm:ss struct {min_tens, min_ones, sec_tens, sec_ones}, and the constants MMSS_MAX = 9959 and MMSS_ZERO.
- One sub-module: bcd_mmss_counter, parameter UP (1 = count up, saturate at 99:59; 0 = count down, saturate at 00:00). Ports: clk, rst_n, i_load, i_load_val, i_en, o_val, o_sat.
- play_timer instantiates it twice and owns the prescaler, edge detect, track logic and output mux.

Test Plan (CLK_HZ=10 in simulation):
- Reset, i_len_bcd=16'h0305, i_pause=0, i_mode=0, run 25 cycles → o_time_bcd=0002, o_tick high for exactly 2 single cycles; then i_mode=1 → 0303 one cycle later.
- Load 16'h0001, i_mode=1, run 30 cycles → counts 0001→0000, o_rem_zero=1 and holds; elapsed continues to 0003.
- Pulse i_pre at track 0 → o_track=NUM_SONGS-1 next cycle; pulse i_next → 0. i_next and i_finish_song rising in the same cycle → single increment only.
- Pause at elapsed 0007 for 50 cycles → value stays 0007 and no o_tick; release → 0008 after exactly CLK_HZ cycles.
- Force elapsed to 9958, run 20 cycles → 9959, o_ovf=1, then i_next → 0000, ovf=0.
- Assert rst_n=0 mid-count at elapsed 0012, asynchronously → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/play_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : play_timer_pkg
//  Description : Shared types and constants for the play timer. Defines a BCD
//                digit, the packed mm:ss time value and its two end points.
//  Revision    : 1.0  initial release
// ============================================================================
package play_timer_pkg;

    typedef logic [3:0] bcd_t;

    // Field order matches the display nibble order {mm, ss}.
    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam mmss_t MMSS_MAX  = 16'h9959;
    localparam mmss_t MMSS_ZERO = 16'h0000;

endpackage : play_timer_pkg
`default_nettype wire

// File: rtl/play_timer_bcd_mmss_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mmss_counter
//  Description : Saturating mm:ss BCD counter. UP=1 counts up and holds at
//                99:59; UP=0 counts down and holds at 00:00.
//  Ports       : clk, rst_n (async, active-low)
//                i_load / i_load_val : synchronous load, wins over i_en
//                i_en                : advance one second
//                o_val               : current value
//                o_sat               : value equals the saturation point
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mmss_counter
    import play_timer_pkg::*;
#(
    parameter bit UP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic [15:0] o_val,
    output logic        o_sat
);

    localparam mmss_t c_sat_val = UP ? MMSS_MAX : MMSS_ZERO;

    mmss_t r_val;
    logic  r_sat;
    mmss_t w_step;
    mmss_t w_next;

    // Digit compares use < / != rather than == so that out-of-range loaded
    // digits still drift back into range instead of sticking.
    generate
        if (UP) begin : g_up
            always_comb begin
                w_step = r_val;
                if (r_val.sec_ones < 4'd9) begin
                    w_step.sec_ones = r_val.sec_ones + 4'd1;
                end else begin
                    w_step.sec_ones = 4'd0;
                    if (r_val.sec_tens < 4'd5) begin
                        w_step.sec_tens = r_val.sec_tens + 4'd1;
                    end else begin
                        w_step.sec_tens = 4'd0;
                        if (r_val.min_ones < 4'd9) begin
                            w_step.min_ones = r_val.min_ones + 4'd1;
                        end else begin
                            w_step.min_ones = 4'd0;
                            w_step.min_tens = r_val.min_tens + 4'd1;
                        end
                    end
                end
            end
        end else begin : g_down
            always_comb begin
                w_step = r_val;
                if (r_val.sec_ones != 4'd0) begin
                    w_step.sec_ones = r_val.sec_ones - 4'd1;
                end else begin
                    w_step.sec_ones = 4'd9;
                    if (r_val.sec_tens != 4'd0) begin
                        w_step.sec_tens = r_val.sec_tens - 4'd1;
                    end else begin
                        w_step.sec_tens = 4'd5;
                        if (r_val.min_ones != 4'd0) begin
                            w_step.min_ones = r_val.min_ones - 4'd1;
                        end else begin
                            w_step.min_ones = 4'd9;
                            w_step.min_tens = r_val.min_tens - 4'd1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_next = r_val;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_en && (r_val != c_sat_val)) begin
            w_next = w_step;
        end
    end

    // Saturation flag is computed from the next value so it stays aligned
    // with o_val rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= MMSS_ZERO;
            r_sat <= 1'b0;
        end else begin
            r_val <= w_next;
            r_sat <= (w_next == c_sat_val);
        end
    end

    assign o_val = r_val;
    assign o_sat = r_sat;

endmodule : bcd_mmss_counter
`default_nettype wire

// File: rtl/play_timer.sv
`default_nettype none
// ============================================================================
//  Module      : play_timer
//  Description : Track index plus elapsed / remaining mm:ss play time in BCD,
//                driving the 7-segment display directly.
//  Ports       : clk, rst_n (async, active-low)
//                i_pause        : level, freezes prescaler and counters
//                i_next / i_pre / i_finish_song : song change requests (edges)
//                i_mode         : 0 elapsed, 1 remaining on o_time_bcd
//                i_len_bcd      : new song length, sampled on a song change
//                o_track        : current track index
//                o_time_bcd     : selected {mm, ss}
//                o_tick         : one-cycle pulse per counted second
//                o_ovf          : elapsed held at 99:59
//                o_rem_zero     : remaining is 00:00
//  Revision    : 1.0  initial release
// ============================================================================
module play_timer
    import play_timer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int NUM_SONGS = 4,
    parameter int TRK_W     = $clog2(NUM_SONGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pause,
    input  logic             i_next,
    input  logic             i_pre,
    input  logic             i_finish_song,
    input  logic             i_mode,
    input  logic [15:0]      i_len_bcd,
    output logic [TRK_W-1:0] o_track,
    output logic [15:0]      o_time_bcd,
    output logic             o_tick,
    output logic             o_ovf,
    output logic             o_rem_zero
);

    localparam int               c_ps_w   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_ps_w-1:0] c_ps_max = c_ps_w'(CLK_HZ - 1);
    localparam logic [TRK_W-1:0]  c_last   = TRK_W'(NUM_SONGS - 1);

    logic              r_next_d;
    logic              r_pre_d;
    logic              r_fin_d;
    logic              r_load_pending;
    logic [c_ps_w-1:0] r_ps;
    logic [TRK_W-1:0]  r_track;
    logic [15:0]       r_time;
    logic              r_tick;

    logic              w_fin_evt;
    logic              w_next_evt;
    logic              w_pre_evt;
    logic              w_fwd;
    logic              w_change;
    logic              w_sec_tick;
    logic [15:0]       w_ela;
    logic [15:0]       w_rem;
    logic              w_ela_sat;
    logic              w_rem_sat;

    assign w_fin_evt  = i_finish_song & ~r_fin_d;
    assign w_next_evt = i_next & ~r_next_d;
    assign w_pre_evt  = i_pre & ~r_pre_d;

    // finish and next both advance, so they share the forward path; a pre
    // edge in the same cycle is simply dropped.
    assign w_fwd      = w_fin_evt | w_next_evt;
    assign w_change   = w_fwd | w_pre_evt;
    assign w_sec_tick = ~i_pause & ~w_change & (r_ps == c_ps_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_d       <= 1'b0;
            r_pre_d        <= 1'b0;
            r_fin_d        <= 1'b0;
            r_load_pending <= 1'b1;
            r_ps           <= '0;
            r_track        <= '0;
            r_time         <= MMSS_ZERO;
            r_tick         <= 1'b0;
        end else begin
            r_next_d       <= i_next;
            r_pre_d        <= i_pre;
            r_fin_d        <= i_finish_song;
            r_load_pending <= 1'b0;
            r_tick         <= w_sec_tick;
            r_time         <= i_mode ? w_rem : w_ela;

            if (w_change) begin
                r_ps <= '0;
            end else if (!i_pause) begin
                r_ps <= (r_ps == c_ps_max) ? '0 : r_ps + 1'b1;
            end

            if (w_fwd) begin
                r_track <= (r_track == c_last) ? '0 : r_track + 1'b1;
            end else if (w_pre_evt) begin
                r_track <= (r_track == '0) ? c_last : r_track - 1'b1;
            end
        end
    end

    bcd_mmss_counter #(
        .UP (1'b1)
    ) u_elapsed (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_change),
        .i_load_val (MMSS_ZERO),
        .i_en       (w_sec_tick),
        .o_val      (w_ela),
        .o_sat      (w_ela_sat)
    );

    // The first clock after reset picks up the length of the song that is
    // already selected, since no change edge may ever arrive for it.
    bcd_mmss_counter #(
        .UP (1'b0)
    ) u_remaining (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_change | r_load_pending),
        .i_load_val (i_len_bcd),
        .i_en       (w_sec_tick),
        .o_val      (w_rem),
        .o_sat      (w_rem_sat)
    );

    assign o_track    = r_track;
    assign o_time_bcd = r_time;
    assign o_tick     = r_tick;
    assign o_ovf      = w_ela_sat;
    assign o_rem_zero = w_rem_sat;

endmodule : play_timer
`default_nettype wire

// File: tb/tb_play_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_play_timer
//  Description : Directed self-checking bench for play_timer (CLK_HZ=10,
//                NUM_SONGS=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_play_timer;

    localparam int CLK_HZ    = 10;
    localparam int NUM_SONGS = 4;
    localparam int TRK_W     = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_pause;
    logic             i_next;
    logic             i_pre;
    logic             i_finish_song;
    logic             i_mode;
    logic [15:0]      i_len_bcd;
    logic [TRK_W-1:0] o_track;
    logic [15:0]      o_time_bcd;
    logic             o_tick;
    logic             o_ovf;
    logic             o_rem_zero;

    int n_total = 0;
    int n_bad   = 0;
    int tick_cnt = 0;

    play_timer #(
        .CLK_HZ    (CLK_HZ),
        .NUM_SONGS (NUM_SONGS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pause       (i_pause),
        .i_next        (i_next),
        .i_pre         (i_pre),
        .i_finish_song (i_finish_song),
        .i_mode        (i_mode),
        .i_len_bcd     (i_len_bcd),
        .o_track       (o_track),
        .o_time_bcd    (o_time_bcd),
        .o_tick        (o_tick),
        .o_ovf         (o_ovf),
        .o_rem_zero    (o_rem_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (o_tick) tick_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; i_pause = 1'b0; i_next = 1'b0; i_pre = 1'b0;
        i_finish_song = 1'b0; i_mode = 1'b0; i_len_bcd = 16'h0305;
        #1;
        chk("rst_track", 32'(o_track), 32'd0);
        chk("rst_time", 32'(o_time_bcd), 32'h0000);
        chk("rst_tick", 32'(o_tick), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_remzero", 32'(o_rem_zero), 32'd0);
        step(2);
        rst_n = 1'b1;

        // Elapsed count and second pulses.
        tick_cnt = 0;
        step(25);
        chk("ela_25cyc", 32'(o_time_bcd), 32'h0002);
        chk("tick_count", 32'(tick_cnt), 32'd2);
        i_mode = 1'b1;
        step(1);
        chk("rem_after_mode", 32'(o_time_bcd), 32'h0303);

        // Load a one-second song and let remaining run out.
        i_len_bcd = 16'h0001; i_next = 1'b1;
        step(1);
        i_next = 1'b0;
        chk("trk_next1", 32'(o_track), 32'd1);
        chk("remzero_load", 32'(o_rem_zero), 32'd0);
        step(11);
        chk("remzero_set", 32'(o_rem_zero), 32'd1);
        chk("rem_0000", 32'(o_time_bcd), 32'h0000);
        step(19);
        chk("remzero_hold", 32'(o_rem_zero), 32'd1);
        chk("rem_hold", 32'(o_time_bcd), 32'h0000);
        i_mode = 1'b0;
        step(1);
        chk("ela_3", 32'(o_time_bcd), 32'h0003);

        // Track wrap and priority.
        i_pre = 1'b1; step(1); i_pre = 1'b0;
        chk("trk_pre_to0", 32'(o_track), 32'd0);
        step(1);
        i_pre = 1'b1; step(1); i_pre = 1'b0;
        chk("trk_pre_wrap", 32'(o_track), 32'd3);
        step(1);
        i_next = 1'b1; step(1); i_next = 1'b0;
        chk("trk_next_wrap", 32'(o_track), 32'd0);
        step(1);
        i_next = 1'b1; i_finish_song = 1'b1; step(1);
        i_next = 1'b0; i_finish_song = 1'b0;
        chk("trk_dual", 32'(o_track), 32'd1);
        step(2);
        chk("trk_dual_hold", 32'(o_track), 32'd1);

        // Pause holds everything.
        i_len_bcd = 16'h0500;
        i_next = 1'b1; step(1); i_next = 1'b0;
        step(71);
        chk("ela_7", 32'(o_time_bcd), 32'h0007);
        i_pause = 1'b1;
        tick_cnt = 0;
        step(50);
        chk("pause_hold", 32'(o_time_bcd), 32'h0007);
        chk("pause_noticks", 32'(tick_cnt), 32'd0);
        i_pause = 1'b0;
        step(9);
        chk("unpause_9", 32'(o_time_bcd), 32'h0007);
        step(1);
        chk("unpause_10", 32'(o_time_bcd), 32'h0008);

        // Elapsed saturation.
        i_next = 1'b1; step(1); i_next = 1'b0;
        force dut.u_elapsed.r_val = 16'h9958;
        #1;
        release dut.u_elapsed.r_val;
        step(20);
        chk("ela_sat", 32'(o_time_bcd), 32'h9959);
        chk("ovf_set", 32'(o_ovf), 32'd1);
        i_next = 1'b1; step(1); i_next = 1'b0;
        chk("ovf_clear", 32'(o_ovf), 32'd0);
        step(1);
        chk("ela_cleared", 32'(o_time_bcd), 32'h0000);

        // Asynchronous reset mid-count.
        i_pre = 1'b1; step(1); i_pre = 1'b0;
        step(121);
        chk("ela_12", 32'(o_time_bcd), 32'h0012);
        chk("trk_before_rst", 32'(o_track), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_track", 32'(o_track), 32'd0);
        chk("arst_time", 32'(o_time_bcd), 32'h0000);
        chk("arst_ovf", 32'(o_ovf), 32'd0);

        // Input held high through reset release counts as an edge.
        i_len_bcd = 16'h0210; i_next = 1'b1; i_mode = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);
        i_next = 1'b0;
        chk("trk_held_edge", 32'(o_track), 32'd1);
        step(1);
        chk("rem_after_rst", 32'(o_time_bcd), 32'h0210);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_play_timer
`default_nettype wire
